// File: rtl/ofm_pad_writer.sv
// rtl/ofm_pad_writer.sv - OFM beat writer into a zero-padded layer-2 IFM buffer.
// The border words are generated only when PAD_WRITE_EN is defined.
module ofm_pad_writer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        OFM_W,
    input  logic [7:0]        OFM_C,
    input  logic              ofm_valid,
    input  logic [DATA_W-1:0] ofm_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       p_q, p_d, ts_q, ts_d;
    logic [7:0]        w_q, w_d, dx_q, dx_d, dy_q, dy_d;
    logic [31:0]       data_left_q, data_left_d;
    logic [ADDR_W-1:0] tile_base_q, tile_base_d, row_base_q, row_base_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              overflow_q, overflow_d;

    logic [31:0]       w_cfg, tiles_cfg, p_cfg, ts_cfg, data_cfg;
    logic [ADDR_W-1:0] row_init, row_init_cfg;
    logic              take_beat, all_done;

`ifdef PAD_WRITE_EN
    typedef enum logic [1:0] {PH_TOP = 2'd0, PH_BOT = 2'd1, PH_SIDE = 2'd2} pad_ph_t;

    pad_ph_t           pad_ph_q, pad_ph_d;
    logic [31:0]       pad_left_q, pad_left_d, pad_x_q, pad_x_d;
    logic              pad_side_q, pad_side_d;
    logic [ADDR_W-1:0] pad_tile_q, pad_tile_d, pad_row_q, pad_row_d, pad_col;
    logic [31:0]       pad_cfg;
    localparam logic [ADDR_W-1:0] COL_OFF = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] COL_OFF = '0;
`endif

    // Layer geometry; the multipliers only see config at start, never the write path.
    always_comb begin
        w_cfg     = {24'd0, OFM_W};
        tiles_cfg = ({24'd0, OFM_C} + 32'd15) >> 4;
`ifdef PAD_WRITE_EN
        p_cfg        = w_cfg + 32'd2;
        row_init_cfg = ADDR_W'(p_cfg);
        row_init     = ADDR_W'(p_q);
        pad_cfg      = tiles_cfg * ((p_cfg << 2) - 32'd4);
        all_done     = (data_left_q == 32'd0) && (pad_left_q == 32'd0);
`else
        p_cfg        = w_cfg;
        row_init_cfg = '0;
        row_init     = '0;
        all_done     = (data_left_q == 32'd0);
`endif
        ts_cfg   = p_cfg * p_cfg;
        data_cfg = w_cfg * w_cfg * tiles_cfg;
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        p_d         = p_q;
        ts_d        = ts_q;
        w_d         = w_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        data_left_d = data_left_q;
        tile_base_d = tile_base_q;
        row_base_d  = row_base_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        overflow_d  = overflow_q;
`ifdef PAD_WRITE_EN
        pad_ph_d   = pad_ph_q;
        pad_left_d = pad_left_q;
        pad_x_d    = pad_x_q;
        pad_side_d = pad_side_q;
        pad_tile_d = pad_tile_q;
        pad_row_d  = pad_row_q;
        if (pad_ph_q == PH_SIDE) begin
            pad_col = pad_side_q ? ADDR_W'(p_q - 32'd1) : '0;
        end else begin
            pad_col = ADDR_W'(pad_x_q);
        end
`endif
        take_beat = (state_q == S_RUN) && ofm_valid && (data_left_q != 32'd0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    overflow_d  = 1'b0;
                    base_d      = base_addr;
                    p_d         = p_cfg;
                    ts_d        = ts_cfg;
                    w_d         = OFM_W;
                    dx_d        = '0;
                    dy_d        = '0;
                    data_left_d = data_cfg;
                    tile_base_d = '0;
                    row_base_d  = row_init_cfg;
`ifdef PAD_WRITE_EN
                    pad_ph_d   = PH_TOP;
                    pad_left_d = pad_cfg;
                    pad_x_d    = '0;
                    pad_side_d = 1'b0;
                    pad_tile_d = '0;
                    pad_row_d  = '0;
`endif
                    state_d = ((OFM_W != 8'd0) && (OFM_C != 8'd0)) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                if (take_beat) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = base_q + tile_base_q + row_base_q + ADDR_W'(dx_q) + COL_OFF;
                    wr_data_d   = ofm_data;
                    data_left_d = data_left_q - 32'd1;
                    if (dx_q == w_q - 8'd1) begin
                        dx_d = '0;
                        if (dy_q == w_q - 8'd1) begin
                            dy_d        = '0;
                            row_base_d  = row_init;
                            tile_base_d = tile_base_q + ADDR_W'(ts_q);
                        end else begin
                            dy_d       = dy_q + 8'd1;
                            row_base_d = row_base_q + ADDR_W'(p_q);
                        end
                    end else begin
                        dx_d = dx_q + 8'd1;
                    end
                end
`ifdef PAD_WRITE_EN
                else if (pad_left_q != 32'd0) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = base_q + pad_tile_q + pad_row_q + pad_col;
                    wr_data_d  = '0;
                    pad_left_d = pad_left_q - 32'd1;
                    // Border walk: top row, bottom row, then left/right pairs of inner rows.
                    case (pad_ph_q)
                        PH_TOP: begin
                            if (pad_x_q == p_q - 32'd1) begin
                                pad_x_d   = '0;
                                pad_ph_d  = PH_BOT;
                                pad_row_d = ADDR_W'(ts_q - p_q);
                            end else begin
                                pad_x_d = pad_x_q + 32'd1;
                            end
                        end
                        PH_BOT: begin
                            if (pad_x_q == p_q - 32'd1) begin
                                pad_x_d    = '0;
                                pad_ph_d   = PH_SIDE;
                                pad_row_d  = ADDR_W'(p_q);
                                pad_side_d = 1'b0;
                            end else begin
                                pad_x_d = pad_x_q + 32'd1;
                            end
                        end
                        default: begin
                            if (!pad_side_q) begin
                                pad_side_d = 1'b1;
                            end else begin
                                pad_side_d = 1'b0;
                                if (pad_row_q == ADDR_W'(ts_q - (p_q << 1))) begin
                                    pad_ph_d   = PH_TOP;
                                    pad_row_d  = '0;
                                    pad_tile_d = pad_tile_q + ADDR_W'(ts_q);
                                end else begin
                                    pad_row_d = pad_row_q + ADDR_W'(p_q);
                                end
                            end
                        end
                    endcase
                end
`endif
                else if (all_done) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ofm_valid && !take_beat) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            p_q         <= '0;
            ts_q        <= '0;
            w_q         <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            data_left_q <= '0;
            tile_base_q <= '0;
            row_base_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            overflow_q  <= 1'b0;
`ifdef PAD_WRITE_EN
            pad_ph_q   <= PH_TOP;
            pad_left_q <= '0;
            pad_x_q    <= '0;
            pad_side_q <= 1'b0;
            pad_tile_q <= '0;
            pad_row_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            p_q         <= p_d;
            ts_q        <= ts_d;
            w_q         <= w_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            data_left_q <= data_left_d;
            tile_base_q <= tile_base_d;
            row_base_q  <= row_base_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            overflow_q  <= overflow_d;
`ifdef PAD_WRITE_EN
            pad_ph_q   <= pad_ph_d;
            pad_left_q <= pad_left_d;
            pad_x_q    <= pad_x_d;
            pad_side_q <= pad_side_d;
            pad_tile_q <= pad_tile_d;
            pad_row_q  <= pad_row_d;
`endif
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_FIN);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ofm_pad_writer.sv
// tb/tb_ofm_pad_writer.sv - self-checking bench for ofm_pad_writer.
`timescale 1ns/1ps
module tb_ofm_pad_writer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  base_addr;
    logic [7:0]   OFM_W;
    logic [7:0]   OFM_C;
    logic         ofm_valid;
    logic [127:0] ofm_data;
    logic         wr_en;
    logic [31:0]  wr_addr;
    logic [127:0] wr_data;
    logic         busy;
    logic         done;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] daq[$];
    logic [31:0] paq[$];

    typedef struct {
        int          w;
        int          c;
        logic [31:0] base;
        int          n_wr;
        int          done_cyc;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    ofm_pad_writer #(.ADDR_W(32), .DATA_W(128)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .OFM_W(OFM_W), .OFM_C(OFM_C), .ofm_valid(ofm_valid), .ofm_data(ofm_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected write addresses straight from the padded-map geometry.
    task automatic build(input int w, input int c, input logic [31:0] base);
        int tiles, p, ts;
        daq.delete();
        paq.delete();
        if (w == 0 || c == 0) return;
        tiles = (c + 15) / 16;
`ifdef PAD_WRITE_EN
        p = w + 2;
`else
        p = w;
`endif
        ts = p * p;
        for (int t = 0; t < tiles; t++)
            for (int y = 0; y < w; y++)
                for (int x = 0; x < w; x++)
`ifdef PAD_WRITE_EN
                    daq.push_back(base + t * ts + (y + 1) * p + x + 1);
`else
                    daq.push_back(base + t * ts + y * p + x);
`endif
`ifdef PAD_WRITE_EN
        for (int t = 0; t < tiles; t++) begin
            for (int x = 0; x < p; x++) paq.push_back(base + t * ts + x);
            for (int x = 0; x < p; x++) paq.push_back(base + t * ts + (p - 1) * p + x);
            for (int r = 1; r < p - 1; r++) begin
                paq.push_back(base + t * ts + r * p);
                paq.push_back(base + t * ts + r * p + p - 1);
            end
        end
`endif
    endtask

    function automatic bit want_valid(input int mode, input int k);
        case (mode)
            0: return 1'b1;
            1: return ($urandom_range(0, 2) == 0);
            2: return (k > 20);
            default: return ((k - 1) % 4 == 0);
        endcase
    endfunction

    // Drives one layer and checks every cycle against the queue model.
    task automatic run_layer(input int w, input int c, input logic [31:0] base, input int mode,
                             input bit v_at_start, input bit extra_v,
                             output int nwr, output int done_cyc);
        int total, sent, z;
        bit exp_wr, exp_ovf;
        logic [31:0] exp_addr;
        logic [127:0] exp_data;
        build(w, c, base);
        total = daq.size();
        sent = 0;
        nwr = 0;
        done_cyc = -1;
        z = (total == 0) ? 0 : -1;
        exp_wr = 0;
        exp_ovf = v_at_start;
        exp_addr = '0;
        exp_data = '0;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        OFM_W = w[7:0];
        OFM_C = c[7:0];
        ofm_valid = v_at_start;
        ofm_data = rnd128();
        for (int k = 1; k < 6000; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            ofm_valid = 1'b0;
            chk("wr_en", wr_en, exp_wr);
            if (exp_wr) begin
                chk("wr_addr", wr_addr, exp_addr);
                chk("wr_data", wr_data, exp_data);
            end
            if (wr_en) nwr++;
            if (done) done_cyc = k;
            chk("busy", busy, (z < 0) || (k <= z));
            chk("done", done, (z >= 0) && (k == z + 1));
            chk("overflow", overflow, exp_ovf);
            if (z >= 0 && k == z + 2) return;
            if (z < 0 && daq.size() == 0 && paq.size() == 0) z = k;
            if (z < 0) begin
                if (sent < total && want_valid(mode, k)) begin
                    ofm_valid = 1'b1;
                    ofm_data = rnd128();
                    sent++;
                    exp_wr = 1'b1;
                    exp_addr = daq.pop_front();
                    exp_data = ofm_data;
                end else if (paq.size() > 0) begin
                    exp_wr = 1'b1;
                    exp_addr = paq.pop_front();
                    exp_data = '0;
                end else begin
                    exp_wr = 1'b0;
                end
            end else begin
                exp_wr = 1'b0;
                if (extra_v && k == z) begin
                    ofm_valid = 1'b1;
                    ofm_data = rnd128();
                    exp_ovf = 1'b1;
                end
            end
            if (mode == 1) begin
                base_addr = $urandom;
                OFM_W = 8'($urandom);
                OFM_C = 8'($urandom);
                start = ((z < 0) || (k <= z + 1)) && ($urandom_range(0, 7) == 0);
            end
        end
        checks++;
        errors++;
        $display("FAIL timeout: layer w=%0d c=%0d did not finish", w, c);
    endtask

    initial begin
        int nwr, dc;
`ifdef PAD_WRITE_EN
        vecs[0] = '{2, 16, 32'h100, 16, 18};
        vecs[1] = '{2, 32, 32'h0, 32, 34};
        vecs[2] = '{3, 16, 32'h40, 25, 27};
        vecs[3] = '{1, 1, 32'h7, 9, 11};
        vecs[4] = '{0, 16, 32'h10, 0, 1};
        vecs[5] = '{4, 0, 32'h10, 0, 1};
        vecs[6] = '{1, 17, 32'hFFFF_FFFC, 18, 20};
`else
        vecs[0] = '{2, 16, 32'h100, 4, 6};
        vecs[1] = '{2, 32, 32'h0, 8, 10};
        vecs[2] = '{3, 16, 32'h40, 9, 11};
        vecs[3] = '{1, 1, 32'h7, 1, 3};
        vecs[4] = '{0, 16, 32'h10, 0, 1};
        vecs[5] = '{4, 0, 32'h10, 0, 1};
        vecs[6] = '{1, 17, 32'hFFFF_FFFC, 2, 4};
`endif
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        OFM_W = '0;
        OFM_C = '0;
        ofm_valid = 1'b0;
        ofm_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 32'h0);
        chk("rst_wr_data", wr_data, 128'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_layer(vecs[i].w, vecs[i].c, vecs[i].base, 0, 1'b0, 1'b0, nwr, dc);
            chk("vec_nwr", nwr, vecs[i].n_wr);
            chk("vec_done_cyc", dc, vecs[i].done_cyc);
        end

        run_layer(2, 32, 32'h0, 3, 1'b0, 1'b0, nwr, dc);
        run_layer(3, 16, 32'h0, 2, 1'b0, 1'b0, nwr, dc);

        // Valid arriving after the last beat, then in IDLE; next start clears the flag.
        run_layer(2, 16, 32'h100, 0, 1'b0, 1'b1, nwr, dc);
        ofm_valid = 1'b1;
        ofm_data = rnd128();
        @(posedge clk); #1;
        ofm_valid = 1'b0;
        chk("idle_valid_wr_en", wr_en, 1'b0);
        chk("idle_valid_overflow", overflow, 1'b1);
        run_layer(2, 16, 32'h300, 0, 1'b0, 1'b0, nwr, dc);
        run_layer(2, 16, 32'h200, 0, 1'b1, 1'b0, nwr, dc);

        // Reset after three data writes, then a clean rerun.
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 32'h100;
        OFM_W = 8'd2;
        OFM_C = 8'd16;
        @(posedge clk); #1;
        start = 1'b0;
        ofm_valid = 1'b1;
        ofm_data = rnd128();
        repeat (3) @(posedge clk);
        #1;
        ofm_valid = 1'b0;
        chk("mid_wr_en", wr_en, 1'b1);
`ifdef PAD_WRITE_EN
        chk("mid_wr_addr", wr_addr, 32'h109);
`else
        chk("mid_wr_addr", wr_addr, 32'h102);
`endif
        reset = 1'b0;
        #1;
        chk("arst_wr_en", wr_en, 1'b0);
        chk("arst_wr_addr", wr_addr, 32'h0);
        chk("arst_wr_data", wr_data, 128'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_overflow", overflow, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_layer(2, 16, 32'h100, 0, 1'b0, 1'b0, nwr, dc);

        for (int i = 0; i < 10; i++) begin
            logic [31:0] b;
            b = (i % 3 == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
            run_layer($urandom_range(1, 5), $urandom_range(1, 48), b, 1, 1'b0, 1'b0, nwr, dc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofm_pad_writer.md
# ofm_pad_writer

Write-side controller between the PE cluster and the layer-2 IFM BRAM (128-bit write port).
- Packs each 16-channel OFM beat from the PE cluster into one 128-bit word.
- Places each word at its position in a zero-padded feature map, ready for the next 3x3 depthwise stage.
- Generates the zero border words itself, in cycles when no OFM beat arrives, so the PE cluster never stalls.

## Interface
Parameters:
- ADDR_W, 32, write-address width.
- DATA_W, 128, word width; 16 lanes × 8 bit, fixed.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches config and begins a layer; ignored while busy.
- base_addr  in  ADDR_W  first word address of the layer-2 buffer.
- OFM_W  in  8  unpadded OFM width = height.
- OFM_C  in  8  OFM channels; tiles = (OFM_C+15)>>4.
- ofm_valid  in  1  one OFM beat present (PE finish pulse).
- ofm_data  in  128  {OFM_15..OFM_0}; lane 0 in bits [7:0].
- wr_en  out  1  BRAM write strobe (drives wr_rd_req_IFM_layer_2).
- wr_addr  out  ADDR_W  BRAM write address.
- wr_data  out  128  BRAM write data.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when all data and pad words are written.
- overflow  out  1  sticky; set by an unexpected ofm_valid; cleared by start or reset.

## Operation
- P = OFM_W + 2 is the padded row pitch.
- TS = P*P is the tile stride.
- Both P and TS are computed at start and held in 32-bit registers.

States:
- IDLE: waits for start.
- RUN: writes data and pad words.
- FIN: issues done, then returns to IDLE.
- IDLE→RUN on start, if OFM_W≠0 and OFM_C≠0. Otherwise IDLE→FIN directly, with no writes.
- RUN→FIN when data_left==0 and pad_left==0.

Data path:
- Counters (dt, dy, dx) run in raster order: dx fastest, then dy, then tile.
- Address = base_addr + dt*TS + (dy+1)*P + (dx+1).
- The address is formed from incrementally accumulated tile_base and row_base. No multiplier in the datapath.
- Each accepted ofm_valid writes ofm_data unchanged at that address.

Pad path:
- Counters walk each tile's border in this order:
  - top row, x = 0..P-1
  - bottom row, x = 0..P-1
  - then, for rows 1..P-2, column 0 followed by column P-1
- That is 4P-4 zero words per tile, tile 0 first.

Arbitration:
- One write per cycle.
- ofm_valid always wins.
- A pad write is issued only in a RUN cycle with ofm_valid low and pad words remaining.

Boundary behaviour:
- ofm_valid in IDLE or FIN, or after all OFM_W*OFM_W*tiles beats: no write and overflow←1.
- ofm_valid in the same cycle as start: treated as unexpected; no write and overflow←1.
- Config inputs are ignored after start; mid-layer changes have no effect.
- Address arithmetic wraps modulo 2^ADDR_W, with no check.
- A reset mid-operation clears all state immediately. Partially written BRAM content is left as is.

## Timing
Reset values:
- wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0; state IDLE.

Latency and pulses:
- wr_en, wr_addr and wr_data are registered: ofm_valid in cycle n gives the write in cycle n+1.
- A pad write chosen in cycle n appears in cycle n+1, with wr_data=0.
- The first possible write is 2 cycles after the start pulse.
- done rises the cycle after the last wr_en cycle and lasts 1 cycle; busy falls in that same cycle.
- A new start is accepted in the cycle after done.
- With no OFM beats arriving, pad writes run back-to-back, one per cycle.

## Configuration
- PAD_WRITE_EN defined:
  - the behaviour above.
- PAD_WRITE_EN undefined:
  - no pad path and no border words;
  - P = OFM_W and address = base_addr + dt*OFM_W² + dy*OFM_W + dx;
  - RUN→FIN when data_left==0.

## Test plan
- Single tile: OFM_W=2, OFM_C=16, base=0x100, start, then 4 back-to-back valids with data D0..D3.
  - Required: data writes at 0x105, 0x106, 0x109, 0x10A in cycles 2..5.
  - Then 12 zero writes at 0x100-0x103, 0x10C-0x10F, 0x104, 0x107, 0x108, 0x10B.
  - done in cycle 18.
- Two tiles: OFM_W=2, OFM_C=32, base=0, 8 valids with 3 idle cycles between each.
  - Required: tile-1 data at 21, 22, 25, 26.
  - 24 pad words fill the gaps.
  - 32 writes total, with no address repeated.
- Idle pads then data: OFM_W=3, OFM_C=16, no valid for 20 cycles.
  - Required: 16 consecutive pad writes, then wr_en=0.
  - 9 later valids write 6, 7, 8, 11, …, 18; done follows the 9th write.
- Overflow: after the test-1 done, one extra valid.
  - Required: no write, overflow=1; the next start clears it.
- Reset mid-layer: assert reset after 3 writes.
  - Required: all outputs 0 in the same cycle, state IDLE.
  - A subsequent start rewrites from the first address.
- Macro off (PAD_WRITE_EN undefined): test-1 stimulus.
  - Required: writes only at 0x100-0x103, and done 1 cycle after the 4th write.
